// File: rtl/collision_detect.sv
// Dino/obstacle collision detector: aligns write-pass pixel tags with sprite ROM
// opacity, counts opaque overlaps per frame and latches a collision when a frame crosses HIT_THRESH.
module collision_detect #(
   parameter int unsigned ROM_LAT    = 2,
   parameter int unsigned HIT_THRESH = 4
) (
   input  logic       Clk50,
   input  logic       Reset_n,
   input  logic       frame_start,
   input  logic       pixel_valid,
   input  logic [9:0] WriteX,
   input  logic [9:0] WriteY,
   input  logic       dino_on_wr,
   input  logic       pterosaur_on_wr,
   input  logic       cactus_on_wr,
   input  logic       dino_opaque,
   input  logic       ptero_opaque,
   input  logic       cactus_opaque,
   input  logic       restart,
   output logic       Dead,
   output logic [9:0] hit_x,
   output logic [9:0] hit_y,
   output logic [1:0] hit_src,
   output logic [7:0] overlap_count
);

   localparam int unsigned XW = 10;
   localparam int unsigned CW = 8;
   localparam int unsigned PW = 2 + 2 * XW + 3;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_SCAN = 2'b01;
   localparam logic [1:0] S_DEAD = 2'b10;

   logic [PW-1:0] r_pipe [ROM_LAT];
   logic [PW-1:0] w_pipe_in;
   logic [PW-1:0] w_pipe_out;
   logic          w_fs_d, w_pv_d, w_dino_d, w_pt_d, w_ca_d;
   logic [XW-1:0] w_x_d, w_y_d;
   logic          w_pt_hit, w_ca_hit, w_overlap;
   logic [1:0]    w_src;

   logic [1:0]    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [XW-1:0] r_sh_x, w_sh_x_nxt;
   logic [XW-1:0] r_sh_y, w_sh_y_nxt;
   logic [1:0]    r_sh_src, w_sh_src_nxt;
   logic          r_dead, w_dead_nxt;
   logic [XW-1:0] r_hit_x, w_hit_x_nxt;
   logic [XW-1:0] r_hit_y, w_hit_y_nxt;
   logic [1:0]    r_hit_src, w_hit_src_nxt;
   logic [CW-1:0] r_oc, w_oc_nxt;

   assign w_pipe_in  = {frame_start, pixel_valid, WriteX, WriteY,
                        dino_on_wr, pterosaur_on_wr, cactus_on_wr};
   assign w_pipe_out = r_pipe[ROM_LAT-1];
   assign {w_fs_d, w_pv_d, w_x_d, w_y_d, w_dino_d, w_pt_d, w_ca_d} = w_pipe_out;

   assign w_pt_hit  = w_pt_d & ptero_opaque;
   assign w_ca_hit  = w_ca_d & cactus_opaque;
   assign w_src     = {w_ca_hit, w_pt_hit};
   assign w_overlap = w_pv_d & w_dino_d & dino_opaque & (w_pt_hit | w_ca_hit);

   // Tag delay line matching the sprite ROM read latency
   always_ff @(posedge Clk50 or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < int'(ROM_LAT); i++) r_pipe[i] <= '0;
      end else if (restart) begin
         for (int i = 0; i < int'(ROM_LAT); i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_pipe_in;
         for (int i = 1; i < int'(ROM_LAT); i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   always_ff @(posedge Clk50 or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_sh_x    <= '0;
         r_sh_y    <= '0;
         r_sh_src  <= '0;
         r_dead    <= 1'b0;
         r_hit_x   <= '0;
         r_hit_y   <= '0;
         r_hit_src <= '0;
         r_oc      <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_sh_x    <= w_sh_x_nxt;
         r_sh_y    <= w_sh_y_nxt;
         r_sh_src  <= w_sh_src_nxt;
         r_dead    <= w_dead_nxt;
         r_hit_x   <= w_hit_x_nxt;
         r_hit_y   <= w_hit_y_nxt;
         r_hit_src <= w_hit_src_nxt;
         r_oc      <= w_oc_nxt;
      end
   end

   // A frame_start_d pixel that overlaps belongs to the frame it opens
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_sh_x_nxt    = r_sh_x;
      w_sh_y_nxt    = r_sh_y;
      w_sh_src_nxt  = r_sh_src;
      w_dead_nxt    = r_dead;
      w_hit_x_nxt   = r_hit_x;
      w_hit_y_nxt   = r_hit_y;
      w_hit_src_nxt = r_hit_src;
      w_oc_nxt      = r_oc;
      if (restart) begin
         w_state_nxt   = S_IDLE;
         w_cnt_nxt     = '0;
         w_sh_x_nxt    = '0;
         w_sh_y_nxt    = '0;
         w_sh_src_nxt  = '0;
         w_dead_nxt    = 1'b0;
         w_hit_x_nxt   = '0;
         w_hit_y_nxt   = '0;
         w_hit_src_nxt = '0;
         w_oc_nxt      = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fs_d) begin
                  w_state_nxt = S_SCAN;
                  if (w_overlap) begin
                     w_cnt_nxt    = CW'(1);
                     w_sh_x_nxt   = w_x_d;
                     w_sh_y_nxt   = w_y_d;
                     w_sh_src_nxt = w_src;
                  end
               end
            end
            S_SCAN: begin
               if (w_fs_d) begin
                  w_oc_nxt = r_cnt;
                  if (r_cnt >= CW'(HIT_THRESH)) begin
                     w_state_nxt   = S_DEAD;
                     w_dead_nxt    = 1'b1;
                     w_hit_x_nxt   = r_sh_x;
                     w_hit_y_nxt   = r_sh_y;
                     w_hit_src_nxt = r_sh_src;
                  end else if (w_overlap) begin
                     w_cnt_nxt    = CW'(1);
                     w_sh_x_nxt   = w_x_d;
                     w_sh_y_nxt   = w_y_d;
                     w_sh_src_nxt = w_src;
                  end else begin
                     w_cnt_nxt    = '0;
                     w_sh_x_nxt   = '0;
                     w_sh_y_nxt   = '0;
                     w_sh_src_nxt = '0;
                  end
               end else if (w_overlap) begin
                  if (r_cnt != {CW{1'b1}}) w_cnt_nxt = r_cnt + CW'(1);
                  if (r_cnt == '0) begin
                     w_sh_x_nxt   = w_x_d;
                     w_sh_y_nxt   = w_y_d;
                     w_sh_src_nxt = w_src;
                  end
               end
            end
            S_DEAD: begin
               w_dead_nxt = 1'b1;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign Dead          = r_dead;
   assign hit_x         = r_hit_x;
   assign hit_y         = r_hit_y;
   assign hit_src       = r_hit_src;
   assign overlap_count = r_oc;

endmodule

// File: tb/tb_collision_detect.sv
// Scoreboard bench for collision_detect: a frame-level model predicts the outputs
// after every frame close, restart and reset; a negedge monitor compares them when due.
module tb_collision_detect;

   localparam int L  = 2;
   localparam int TH = 4;

   logic       Clk50 = 1'b0;
   logic       Reset_n;
   logic       frame_start, pixel_valid;
   logic [9:0] WriteX, WriteY;
   logic       dino_on_wr, pterosaur_on_wr, cactus_on_wr;
   logic       dino_opaque, ptero_opaque, cactus_opaque;
   logic       restart;
   logic       Dead;
   logic [9:0] hit_x, hit_y;
   logic [1:0] hit_src;
   logic [7:0] overlap_count;

   collision_detect #(.ROM_LAT(L), .HIT_THRESH(TH)) dut (
      .Clk50(Clk50), .Reset_n(Reset_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
      .WriteX(WriteX), .WriteY(WriteY), .dino_on_wr(dino_on_wr),
      .pterosaur_on_wr(pterosaur_on_wr), .cactus_on_wr(cactus_on_wr),
      .dino_opaque(dino_opaque), .ptero_opaque(ptero_opaque), .cactus_opaque(cactus_opaque),
      .restart(restart), .Dead(Dead), .hit_x(hit_x), .hit_y(hit_y), .hit_src(hit_src),
      .overlap_count(overlap_count)
   );

   always #5 Clk50 = ~Clk50;

   int cyc = 0;
   always @(posedge Clk50) cyc <= cyc + 1;

   typedef struct {
      int         due;
      string      tag;
      logic       dead;
      logic [7:0] oc;
      logic [9:0] hx, hy;
      logic [1:0] hs;
   } exp_t;

   typedef struct {
      logic [9:0] x, y;
      logic [1:0] src;
   } hit_t;

   typedef enum int {M_IDLE, M_SCAN, M_DEAD} mst_t;

   exp_t exp_q[$];
   hit_t m_frame[$];
   mst_t m_st;
   logic       m_dead;
   logic [7:0] m_oc;
   logic [9:0] m_hx, m_hy;
   logic [1:0] m_hs;
   logic [2:0] op_buf [16];

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model (frame level) ----------------
   task automatic push_exp(input int due, input string tag);
      exp_t e;
      e.due = due; e.tag = tag; e.dead = m_dead; e.oc = m_oc;
      e.hx = m_hx; e.hy = m_hy; e.hs = m_hs;
      exp_q.push_back(e);
   endtask

   task automatic model_clear();
      m_st = M_IDLE; m_dead = 1'b0; m_oc = '0; m_hx = '0; m_hy = '0; m_hs = '0;
      m_frame.delete();
   endtask

   task automatic model_fs(input int due);
      int n;
      case (m_st)
         M_IDLE: begin m_st = M_SCAN; m_frame.delete(); end
         M_SCAN: begin
            n = m_frame.size();
            if (n > 255) n = 255;
            m_oc = 8'(n);
            if (n >= TH) begin
               m_st = M_DEAD; m_dead = 1'b1;
               m_hx = m_frame[0].x; m_hy = m_frame[0].y; m_hs = m_frame[0].src;
            end
            m_frame.delete();
         end
         default: ;
      endcase
      push_exp(due, "frame");
   endtask

   task automatic model_px(input logic pv, input logic [9:0] x, y,
                           input logic d, p, c, dq, pq, cq);
      hit_t h;
      logic ph, ch;
      ph = p & pq;
      ch = c & cq;
      if (m_st == M_SCAN && pv && d && dq && (ph || ch)) begin
         h.x = x; h.y = y; h.src = {ch, ph};
         m_frame.push_back(h);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic fs, pv, input logic [9:0] x, y,
                        input logic d, p, c, dq, pq, cq, rs, input bit mdl);
      int k;
      k = cyc;
      frame_start = fs; pixel_valid = pv; WriteX = x; WriteY = y;
      dino_on_wr = d; pterosaur_on_wr = p; cactus_on_wr = c; restart = rs;
      op_buf[(k + L) % 16] = {dq, pq, cq};
      {dino_opaque, ptero_opaque, cactus_opaque} = op_buf[k % 16];
      op_buf[k % 16] = '0;
      if (rs) begin
         model_clear();
         push_exp(k + 1, "restart");
      end else if (mdl) begin
         if (fs) model_fs(k + 1 + L);
         model_px(pv, x, y, d, p, c, dq, pq, cq);
      end
      @(posedge Clk50); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, '0, '0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic fstart();
      drive(1, 0, '0, '0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic ovl(input logic [9:0] x, y, input logic p, c, fs);
      drive(fs, 1, x, y, 1, p, c, 1, p, c, 0, 1);
   endtask

   task automatic do_restart();
      idle(L + 1);
      drive(0, 0, '0, '0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(L + 1);
   endtask

   task automatic do_reset();
      frame_start = 0; pixel_valid = 0; WriteX = '0; WriteY = '0;
      dino_on_wr = 0; pterosaur_on_wr = 0; cactus_on_wr = 0;
      dino_opaque = 0; ptero_opaque = 0; cactus_opaque = 0; restart = 0;
      for (int i = 0; i < 16; i++) op_buf[i] = '0;
      Reset_n = 1'b0;
      model_clear();
      push_exp(cyc + 1, "reset");
      repeat (2) @(posedge Clk50);
      @(negedge Clk50);
      Reset_n = 1'b1;
      @(posedge Clk50); #1;
   endtask

   task automatic rand_px(input logic fs);
      logic pv, d, p, c, dq, pq, cq;
      logic [9:0] x, y;
      pv = ($urandom_range(0, 7) != 0);
      d  = ($urandom_range(0, 3) != 0);
      dq = ($urandom_range(0, 3) != 0);
      p  = ($urandom_range(0, 3) != 0);
      pq = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 3) != 0);
      cq = ($urandom_range(0, 3) != 0);
      x  = 10'($urandom);
      y  = 10'($urandom);
      drive(fs, pv, x, y, d, p, c, dq, pq, cq, 0, 1);
   endtask

   // ---------------- monitor ----------------
   task automatic chk(input string tag, input string fld, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s.%s @cyc %0d: got %0d expected %0d", tag, fld, cyc, act, exp_v);
      end
   endtask

   always @(negedge Clk50) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.due < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL %s.missed due %0d at cyc %0d", e.tag, e.due, cyc);
         end else begin
            chk(e.tag, "Dead", int'(Dead), int'(e.dead));
            chk(e.tag, "overlap_count", int'(overlap_count), int'(e.oc));
            chk(e.tag, "hit_x", int'(hit_x), int'(e.hx));
            chk(e.tag, "hit_y", int'(hit_y), int'(e.hy));
            chk(e.tag, "hit_src", int'(hit_src), int'(e.hs));
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      for (int i = 0; i < 16; i++) op_buf[i] = '0;
      frame_start = 0; pixel_valid = 0; WriteX = '0; WriteY = '0;
      dino_on_wr = 0; pterosaur_on_wr = 0; cactus_on_wr = 0;
      dino_opaque = 0; ptero_opaque = 0; cactus_opaque = 0; restart = 0;
      Reset_n = 1'b0;
      model_clear();
      push_exp(1, "reset");
      repeat (2) @(posedge Clk50);
      @(negedge Clk50);
      Reset_n = 1'b1;
      @(posedge Clk50); #1;

      // three overlaps then close: below threshold
      fstart();
      for (int i = 0; i < 3; i++) ovl(10'(100 + i), 10'(50), 1, 0, 0);
      fstart();
      // four overlaps, first ptero-only at (200,270): fatal frame
      ovl(10'd200, 10'd270, 1, 0, 0);
      ovl(10'd201, 10'd270, 1, 1, 0);
      ovl(10'd202, 10'd271, 0, 1, 0);
      ovl(10'd203, 10'd272, 1, 0, 0);
      fstart();
      // frames in DEAD are ignored
      fstart();
      ovl(10'd5, 10'd6, 1, 1, 0);
      fstart();
      fstart();
      do_restart();
      fstart();
      ovl(10'd7, 10'd8, 0, 1, 0);
      ovl(10'd9, 10'd8, 0, 1, 0);
      fstart();
      // transparent bounding-box overlap rejected
      for (int i = 0; i < 50; i++)
         drive(0, 1, 10'($urandom), 10'($urandom), 1, 1, 0, 1, 0, 0, 0, 1);
      fstart();
      // overlap on the frame_start pixel opens the new frame
      ovl(10'd11, 10'd12, 1, 0, 0);
      ovl(10'd13, 10'd14, 1, 0, 0);
      ovl(10'd15, 10'd16, 0, 1, 1);
      fstart();
      // saturation
      for (int i = 0; i < 300; i++) ovl(10'(i), 10'(i + 3), 0, 1, 0);
      fstart();
      do_restart();
      // restart coinciding with a fatal frame close
      fstart();
      for (int i = 0; i < 5; i++) ovl(10'(300 + i), 10'd40, 1, 1, 0);
      drive(1, 0, '0, '0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(L - 1);
      drive(0, 0, '0, '0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(L + 1);
      fstart();
      // reset mid-frame
      for (int i = 0; i < 3; i++) ovl(10'(20 + i), 10'd30, 1, 0, 0);
      idle(L + 1);
      do_reset();
      ovl(10'd1, 10'd2, 1, 0, 0);
      fstart();
      ovl(10'd3, 10'd4, 0, 1, 0);
      fstart();
      // randomized frames
      for (int f = 0; f < 40; f++) begin
         rand_px(1);
         repeat ($urandom_range(0, 10)) rand_px(0);
         if (m_st == M_DEAD || $urandom_range(0, 9) == 0) do_restart();
      end
      fstart();
      idle(L + 3);
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge Clk50);
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_tests++; n_fail++;
         $display("FAIL %s.timeout due %0d never checked (cyc %0d)", e.tag, e.due, cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
